instr_register_pipe: RTL and testbench

- Parametrised successor of the lab instruction register: a DEPTH-entry register file of instruction words, each holding opcode, operands, computed result and status flags.
- Adds a valid/ready load handshake, an iterative multi-cycle signed divider, divide-by-zero flagging, and a registered read port with a valid strobe.
- Sits between the test-side instruction generator and the result checker in the lab DUT.

---
 rtl/instr_register_pkg.sv | 42 ++++
 rtl/instr_divider.sv | 87 ++++++++
 rtl/instr_register_pipe.sv | 184 ++++++++++++++++++
 tb/tb_instr_register_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the pipelined instruction register: opcodes, operand/result
// widths, the stored instruction word and the divide sequencing states.
package instr_register_pkg;

  localparam int unsigned PKG_OP_WIDTH  = 32;
  localparam int unsigned PKG_RES_WIDTH = 2 * PKG_OP_WIDTH;
  localparam int unsigned PKG_DEPTH     = 32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [PKG_OP_WIDTH-1:0]  operand_t;
  typedef logic signed [PKG_RES_WIDTH-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
    logic     div_err;
    logic     valid;
  } instruction_t;

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StWrite
  } div_state_t;

  function automatic logic is_div_op(input opcode_t op);
    return (op == DIV) || (op == MOD);
  endfunction

endpackage

// File: rtl/instr_divider.sv
// Iterative restoring signed divider, one quotient bit per cycle. The first
// bit is resolved on the start edge, so done pulses WIDTH-1 cycles later.
module instr_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH:0]   quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_by_zero
);

  localparam int unsigned CntWidth = $clog2(WIDTH);

  logic [WIDTH-1:0]    rem_q, dq_q, den_q;
  logic                neg_quo_q, neg_rem_q, busy_q, done_q, dbz_q;
  logic [CntWidth-1:0] cnt_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_in, dq_in, den_in, rem_nx, dq_nx;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    a_mag   = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag   = divisor[WIDTH-1] ? -divisor : divisor;
    rem_in  = start ? '0 : rem_q;
    dq_in   = start ? a_mag : dq_q;
    den_in  = start ? b_mag : den_q;
    shifted = {rem_in, dq_in[WIDTH-1]};
    diff    = shifted - {1'b0, den_in};
    // Restore (keep the shifted partial remainder) when the trial subtract goes negative.
    if (!diff[WIDTH]) begin
      rem_nx = diff[WIDTH-1:0];
      dq_nx  = {dq_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      dq_nx  = {dq_in[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q     <= '0;
      dq_q      <= '0;
      den_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q     <= rem_nx;
        dq_q      <= dq_nx;
        den_q     <= b_mag;
        neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_rem_q <= dividend[WIDTH-1];
        dbz_q     <= (divisor == '0);
        cnt_q     <= CntWidth'(1);
        busy_q    <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_nx;
        dq_q  <= dq_nx;
        cnt_q <= cnt_q + CntWidth'(1);
        if (cnt_q == CntWidth'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // Quotient carries an extra bit so most-negative / -1 stays positive.
  assign quotient    = neg_quo_q ? -$signed({1'b0, dq_q}) : $signed({1'b0, dq_q});
  assign remainder   = neg_rem_q ? -$signed(rem_q) : $signed(rem_q);
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: rtl/instr_register_pipe.sv
// Instruction register file with valid/ready loading, single-cycle ALU ops,
// a multi-cycle signed divider and a registered read port.
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter int unsigned OP_WIDTH   = PKG_OP_WIDTH,
  parameter int unsigned RES_WIDTH  = 2 * OP_WIDTH,
  parameter int unsigned DEPTH      = PKG_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load_en,
  output logic                       load_ready,
  input  opcode_t                    opcode,
  input  logic signed [OP_WIDTH-1:0] operand_a,
  input  logic signed [OP_WIDTH-1:0] operand_b,
  input  logic [ADDR_WIDTH-1:0]      write_pointer,
  output logic                       wr_done,
  input  logic                       read_en,
  input  logic [ADDR_WIDTH-1:0]      read_pointer,
  output logic                       rd_valid,
  output instruction_t               instruction_word
);

  if (OP_WIDTH < 2) begin : gen_bad_op_width
    $error("OP_WIDTH must be at least 2");
  end
  if (RES_WIDTH < 2 * OP_WIDTH) begin : gen_bad_res_width
    $error("RES_WIDTH must be at least 2*OP_WIDTH");
  end
  if (DEPTH < 2) begin : gen_bad_depth
    $error("DEPTH must be at least 2");
  end
  // The stored word layout is fixed by the package widths.
  if (OP_WIDTH != PKG_OP_WIDTH || RES_WIDTH != PKG_RES_WIDTH) begin : gen_bad_pkg_width
    $error("OP_WIDTH/RES_WIDTH must match instr_register_pkg");
  end

  function automatic logic ptr_ok(input logic [ADDR_WIDTH-1:0] p);
    return 32'(p) < DEPTH;
  endfunction

  div_state_t              state_q;
  logic                    load_ready_q;
  logic                    stage_vld_q;
  instruction_t            stage_word_q;
  logic [ADDR_WIDTH-1:0]   stage_ptr_q;
  opcode_t                 pend_opc_q;
  operand_t                pend_a_q, pend_b_q;
  logic [ADDR_WIDTH-1:0]   pend_ptr_q;
  instruction_t            iw_q [DEPTH];

  logic                    accept, start_div, div_busy, div_done, div_dbz;
  logic signed [OP_WIDTH:0]   div_quo;
  logic signed [OP_WIDTH-1:0] div_rem;
  logic signed [OP_WIDTH-1:0] op_b_s;
  logic signed [RES_WIDTH-1:0] a_ext, b_ext;
  instruction_t            acc_word, div_word;

  always_comb begin
    op_b_s = operand_b;
`ifdef FORCE_LOAD_ERROR
    op_b_s = operand_a;
`endif
  end

  assign load_ready = load_ready_q & ~div_busy;
  assign accept     = load_en & load_ready;
  assign start_div  = accept & is_div_op(opcode) & (op_b_s != '0);

  always_comb begin
    a_ext            = RES_WIDTH'(operand_a);
    b_ext            = RES_WIDTH'(op_b_s);
    acc_word         = '0;
    acc_word.opc     = opcode;
    acc_word.op_a    = operand_a;
    acc_word.op_b    = op_b_s;
    acc_word.valid   = 1'b1;
    case (opcode)
      ZERO:     acc_word.result = '0;
      PASSA:    acc_word.result = a_ext;
      PASSB:    acc_word.result = b_ext;
      ADD:      acc_word.result = a_ext + b_ext;
      SUB:      acc_word.result = a_ext - b_ext;
      MULT:     acc_word.result = a_ext * b_ext;
      // Only reaches the stage when the divisor is zero.
      DIV, MOD: acc_word.div_err = 1'b1;
      default:  acc_word.result = '0;
    endcase
  end

  always_comb begin
    div_word         = '0;
    div_word.opc     = pend_opc_q;
    div_word.op_a    = pend_a_q;
    div_word.op_b    = pend_b_q;
    div_word.result  = (pend_opc_q == MOD) ? RES_WIDTH'(div_rem) : RES_WIDTH'(div_quo);
    div_word.div_err = div_dbz;
    div_word.valid   = 1'b1;
  end

  instr_divider #(
    .WIDTH(OP_WIDTH)
  ) u_divider (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start_div),
    .dividend    (operand_a),
    .divisor     (op_b_s),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quo),
    .remainder   (div_rem),
    .div_by_zero (div_dbz)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      load_ready_q <= 1'b1;
      stage_vld_q  <= 1'b0;
      stage_word_q <= '0;
      stage_ptr_q  <= '0;
      pend_opc_q   <= ZERO;
      pend_a_q     <= '0;
      pend_b_q     <= '0;
      pend_ptr_q   <= '0;
    end else begin
      stage_vld_q <= 1'b0;
      case (state_q)
        StIdle, StWrite: begin
          state_q <= StIdle;
          if (start_div) begin
            state_q      <= StDivide;
            load_ready_q <= 1'b0;
            pend_opc_q   <= opcode;
            pend_a_q     <= operand_a;
            pend_b_q     <= op_b_s;
            pend_ptr_q   <= write_pointer;
          end else if (accept) begin
            stage_vld_q  <= 1'b1;
            stage_word_q <= acc_word;
            stage_ptr_q  <= write_pointer;
          end
        end
        StDivide: begin
          if (div_done) begin
            state_q      <= StWrite;
            load_ready_q <= 1'b1;
            stage_vld_q  <= 1'b1;
            stage_word_q <= div_word;
            stage_ptr_q  <= pend_ptr_q;
          end
        end
        default: begin
          state_q      <= StIdle;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        iw_q[i] <= '0;
      end
      wr_done          <= 1'b0;
      rd_valid         <= 1'b0;
      instruction_word <= '0;
    end else begin
      wr_done <= stage_vld_q;
      if (stage_vld_q && ptr_ok(stage_ptr_q)) begin
        iw_q[stage_ptr_q] <= stage_word_q;
      end
      rd_valid <= read_en;
      if (read_en) begin
        instruction_word <= ptr_ok(read_pointer) ? iw_q[read_pointer] : '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed bench for instr_register_pipe: loads, divides, reads and reset abort.
module tb_instr_register_pipe;
  import instr_register_pkg::*;

  logic         clk, reset_n, load_en, load_ready, wr_done, read_en, rd_valid;
  opcode_t      opcode;
  logic signed [31:0] operand_a, operand_b;
  logic [4:0]   write_pointer, read_pointer;
  instruction_t instruction_word;

  int n_checks = 0;
  int n_fail   = 0;
  int lowcnt;
  int wcnt;

  instr_register_pipe dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .load_ready       (load_ready),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .wr_done          (wr_done),
    .read_en          (read_en),
    .read_pointer     (read_pointer),
    .rd_valid         (rd_valid),
    .instruction_word (instruction_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input instruction_t obs, input instruction_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input logic signed [31:0] a,
                                      input logic signed [31:0] b, input logic signed [63:0] r,
                                      input logic e);
    instruction_t w;
    w.opc = o; w.op_a = a; w.op_b = b; w.result = r; w.div_err = e; w.valid = 1'b1;
    return w;
  endfunction

  task automatic drive(input opcode_t o, input logic signed [31:0] a,
                       input logic signed [31:0] b, input logic [4:0] p);
    load_en = 1'b1; opcode = o; operand_a = a; operand_b = b; write_pointer = p;
  endtask

  task automatic rd(input logic [4:0] p);
    read_en = 1'b1; read_pointer = p;
    tick();
    read_en = 1'b0;
  endtask

  // Counts cycles with load_ready low, bounded so a stuck DUT still finishes.
  task automatic wait_ready(inout int cnt);
    for (int i = 0; i < 100 && !load_ready; i++) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1; load_en = 1'b0; read_en = 1'b0; opcode = ZERO;
    operand_a = '0; operand_b = '0; write_pointer = '0; read_pointer = '0;
    #1 reset_n = 1'b0;
    #20;
    chk1("reset_load_ready", load_ready, 1'b1);
    chk1("reset_wr_done", wr_done, 1'b0);
    chk1("reset_rd_valid", rd_valid, 1'b0);
    chkw("reset_iw", instruction_word, '0);
    tick();
    reset_n = 1'b1;
    tick();

    rd(5'd0);
    chk1("rd0_valid", rd_valid, 1'b1);
    chkw("rd0_word", instruction_word, '0);
    rd(5'd31);
    chk1("rd31_valid", rd_valid, 1'b1);
    chkw("rd31_word", instruction_word, '0);
    tick();
    chk1("rd_idle_valid", rd_valid, 1'b0);

    // Back-to-back single-cycle loads.
    drive(ADD, 32'sd5, -32'sd7, 5'd0);
    chk1("b2b_ready0", load_ready, 1'b1);
    tick();
    drive(MULT, -32'sd3, 32'sd4, 5'd1);
    chk1("b2b_ready1", load_ready, 1'b1);
    chk1("b2b_wr_done_early", wr_done, 1'b0);
    tick();
    load_en = 1'b0;
    chk1("b2b_wr_done0", wr_done, 1'b1);
    tick();
    chk1("b2b_wr_done1", wr_done, 1'b1);
    tick();
    chk1("b2b_wr_done_end", wr_done, 1'b0);
    rd(5'd0);
    chkw("add_entry0", instruction_word, mk(ADD, 5, -7, -64'sd2, 1'b0));
    rd(5'd1);
    chkw("mult_entry1", instruction_word, mk(MULT, -3, 4, -64'sd12, 1'b0));

    // SUB at the negative boundary and PASSB.
    drive(SUB, 32'sh8000_0000, 32'sd1, 5'd10);
    tick();
    drive(PASSB, 32'sd0, -32'sd5, 5'd11);
    tick();
    load_en = 1'b0;
    tick();
    rd(5'd10);
    chkw("sub_no_overflow", instruction_word,
         mk(SUB, 32'sh8000_0000, 1, 64'shFFFF_FFFF_7FFF_FFFF, 1'b0));
    rd(5'd11);
    chkw("passb_entry11", instruction_word, mk(PASSB, 0, -5, -64'sd5, 1'b0));

    // DIV(-17,5): 32 cycles not ready, write one edge after ready returns.
    drive(DIV, -32'sd17, 32'sd5, 5'd2);
    tick();
    load_en = 1'b0;
    lowcnt = 0;
    wait_ready(lowcnt);
    chkn("div_low_cycles", lowcnt, 32);
    chk1("div_write_cycle_wr_done", wr_done, 1'b0);
    tick();
    chk1("div_wr_done", wr_done, 1'b1);
    rd(5'd2);
    chkw("div_entry2", instruction_word, mk(DIV, -17, 5, -64'sd3, 1'b0));

    // Remainder of -17 by 5, with an ignored load request while busy.
    drive(MOD, -32'sd17, 32'sd5, 5'd3);
    tick();
    drive(ADD, 32'sd1, 32'sd1, 5'd7);
    lowcnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (!load_ready) lowcnt++;
      tick();
    end
    load_en = 1'b0;
    wait_ready(lowcnt);
    chkn("mod_low_cycles", lowcnt, 32);
    tick();
    tick();
    rd(5'd3);
    chkw("mod_entry3", instruction_word, mk(MOD, -17, 5, -64'sd2, 1'b0));
    rd(5'd7);
    chkw("busy_load_ignored", instruction_word, '0);

    // Divide by zero takes the single-cycle path.
    drive(DIV, 32'sd100, 32'sd0, 5'd4);
    tick();
    load_en = 1'b0;
    chk1("dbz_ready", load_ready, 1'b1);
    tick();
    chk1("dbz_wr_done", wr_done, 1'b1);
    rd(5'd4);
    chkw("dbz_entry4", instruction_word, mk(DIV, 100, 0, 64'sd0, 1'b1));

    // Most-negative / -1.
    drive(DIV, 32'sh8000_0000, -32'sd1, 5'd5);
    tick();
    load_en = 1'b0;
    lowcnt = 0;
    wait_ready(lowcnt);
    chkn("minneg_low_cycles", lowcnt, 32);
    tick();
    tick();
    rd(5'd5);
    chkw("minneg_entry5", instruction_word,
         mk(DIV, 32'sh8000_0000, -1, 64'sh0000_0000_8000_0000, 1'b0));

    // Same-edge read and write of entry 6 returns the old word.
    drive(ADD, 32'sd1, 32'sd2, 5'd6);
    tick();
    load_en = 1'b0;
    tick();
    drive(PASSA, 32'sd9, 32'sd0, 5'd6);
    tick();
    load_en = 1'b0;
    rd(5'd6);
    chk1("rw_same_wr_done", wr_done, 1'b1);
    chkw("rw_same_old", instruction_word, mk(ADD, 1, 2, 64'sd3, 1'b0));
    rd(5'd6);
    chkw("rw_same_new", instruction_word, mk(PASSA, 9, 0, 64'sd9, 1'b0));

    // Reset in the middle of a divide aborts it and clears the file.
    drive(DIV, 32'sd50, 32'sd7, 5'd9);
    tick();
    load_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk1("mid_div_busy", load_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    chk1("mid_reset_ready", load_ready, 1'b1);
    chkw("mid_reset_iw", instruction_word, '0);
    tick();
    reset_n = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_done) wcnt++;
    end
    chkn("abort_no_write", wcnt, 0);
    chk1("abort_ready", load_ready, 1'b1);
    rd(5'd9);
    chkw("abort_entry9", instruction_word, '0);
    rd(5'd2);
    chkw("abort_entry2", instruction_word, '0);
    rd(5'd6);
    chkw("abort_entry6", instruction_word, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
